// File: rtl/target_ddr_word_rx.sv
// target_ddr_word_rx: HDR-DDR word receiver; samples SDA on SCL edge strobes, checks parity/token/CRC5, decodes address, queues words in a FIFO.
module target_ddr_word_rx #(
  parameter int WORD_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter logic [6:0] MY_ADDR = 7'h66
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_rx_en,
  input  logic              i_scl_pos_edge,
  input  logic              i_scl_neg_edge,
  input  logic              i_sda,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic [WORD_W-1:0] o_word_data,
  output logic [1:0]        o_word_kind,
  output logic [1:0]        o_word_hit,
  output logic [2:0]        o_word_err,
  output logic              o_overflow
);
  localparam int CW = $clog2(WORD_W + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = WORD_W + 7;
  localparam logic [WORD_W-1:0] ODD = {(WORD_W / 2){2'b10}};
  localparam logic [WORD_W-1:0] EVEN = {(WORD_W / 2){2'b01}};
  typedef enum logic [2:0] {IDLE, PRE, CMD, DATA, PAR, TOKEN, CRCV} state_t;
  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_len;
  logic [WORD_W-1:0] r_sh;
  logic [3:0] r_aux;
  logic [4:0] r_crc, w_aux_n, w_crc_n;
  logic r_first, r_tok_err, r_cmd, r_pend;
  logic [EW-1:0] r_pend_e, w_push_e;
  logic w_bit, w_last, w_push, w_p1, w_p0, w_par_bad;
  logic [1:0] w_hit;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic w_full, w_pop, w_wr;
  logic [EW-1:0] w_head;
  assign w_bit = i_rx_en & (i_scl_pos_edge | i_scl_neg_edge);
  assign w_aux_n = {r_aux, i_sda};
  assign w_len = (r_state == CMD || r_state == DATA) ? CW'(WORD_W) :
                 r_state == TOKEN ? CW'(4) : r_state == CRCV ? CW'(5) : CW'(2);
  assign w_last = w_bit && r_state != IDLE && r_cnt == w_len - CW'(1);
  assign w_crc_n = {r_crc[3:0], 1'b0} ^ ((r_crc[4] ^ i_sda) ? 5'h05 : 5'h00);
  // command parity also covers the preamble's trailing '1'
  assign w_p1 = ^(r_sh & ODD) ^ r_cmd;
  assign w_p0 = ~^(r_sh & EVEN);
  assign w_par_bad = w_aux_n[1:0] != {w_p1, w_p0};
  assign w_hit = !r_cmd ? 2'b00 : r_sh[7:1] == MY_ADDR ? 2'b01 : r_sh[7:1] == 7'h7E ? 2'b10 : 2'b00;
  always_ff @(posedge i_sys_clk or posedge i_sys_rst)
    if (i_sys_rst) r_state <= IDLE;
    else r_state <= w_state_n;
  always_comb begin
    w_state_n = r_state;
    w_push = 1'b0;
    w_push_e = '0;
    if (!i_rx_en) w_state_n = IDLE;
    else
      case (r_state)
        IDLE: w_state_n = PRE;
        PRE:
          if (w_last) begin
            if (w_aux_n[1:0] == 2'b01) w_state_n = r_first ? TOKEN : CMD;
            else if (w_aux_n[1:0] == 2'b11) w_state_n = DATA;
            else begin
              w_push = 1'b1;
              w_push_e = {WORD_W'(1'b0), 2'b01, 2'b00, 3'b001};
            end
          end
        CMD, DATA: if (w_last) w_state_n = PAR;
        PAR:
          if (w_last) begin
            w_state_n = PRE;
            w_push = 1'b1;
            w_push_e = {r_sh, r_cmd ? 2'b00 : 2'b01, w_hit, 2'b00, w_par_bad};
          end
        TOKEN: if (w_last) w_state_n = CRCV;
        CRCV:
          if (w_last) begin
            w_state_n = PRE;
            w_push = 1'b1;
            w_push_e = {WORD_W'(w_aux_n), 2'b10, 2'b00, r_tok_err, w_aux_n != r_crc, 1'b0};
          end
        default: w_state_n = IDLE;
      endcase
  end
  always_ff @(posedge i_sys_clk or posedge i_sys_rst)
    if (i_sys_rst) begin
      r_cnt <= '0;
      r_sh <= '0;
      r_aux <= '0;
      r_crc <= 5'h1F;
      r_first <= 1'b0;
      r_tok_err <= 1'b0;
      r_cmd <= 1'b0;
      r_pend <= 1'b0;
      r_pend_e <= '0;
    end else begin
      r_pend <= w_push;
      r_pend_e <= w_push_e;
      if (!i_rx_en) begin
        r_first <= 1'b0;
        r_cnt <= '0;
      end else if (w_bit && r_state != IDLE) begin
        r_aux <= w_aux_n[3:0];
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        if (r_state == CMD || r_state == DATA) r_sh <= {r_sh[WORD_W-2:0], i_sda};
        if (r_state == DATA) r_crc <= w_crc_n;
        if (r_state == TOKEN && w_last) r_tok_err <= w_aux_n[3:0] != 4'b1100;
        if (r_state == PRE && w_last && w_aux_n[1:0] == 2'b01 && !r_first) begin
          r_crc <= 5'h1F;
          r_first <= 1'b1;
          r_cmd <= 1'b1;
        end
        if (r_state == PRE && w_last && w_aux_n[1:0] == 2'b11) r_cmd <= 1'b0;
        if (r_state == CRCV && w_last) r_first <= 1'b0;
      end
    end
  assign o_word_valid = r_count != '0;
  assign w_full = r_count == (AW + 1)'(FIFO_DEPTH);
  assign w_pop = o_word_valid & i_word_ready;
  // a pop frees the slot in the same cycle, so a full FIFO still accepts the push
  assign w_wr = r_pend & (!w_full | w_pop);
  always_ff @(posedge i_sys_clk or posedge i_sys_rst)
    if (i_sys_rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_count <= r_count + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
      if (r_pend && !w_wr) o_overflow <= 1'b1;
    end
  always_ff @(posedge i_sys_clk)
    if (w_wr) r_mem[r_wp] <= r_pend_e;
  assign w_head = o_word_valid ? r_mem[r_rp] : '0;
  assign {o_word_data, o_word_kind, o_word_hit, o_word_err} = w_head;
endmodule

// File: tb/tb_target_ddr_word_rx.sv
// tb_target_ddr_word_rx: scoreboard bench for target_ddr_word_rx with directed DDR words.
module tb_target_ddr_word_rx;
  logic clk = 0, rst = 1, rx_en = 0, pos = 0, neg = 0, sda = 0, rdy = 1;
  logic valid, ovf;
  logic [15:0] data;
  logic [1:0] kind, hit;
  logic [2:0] err;
  logic [22:0] q[$];
  int n_vec = 0, n_err = 0, ph = 0;
  target_ddr_word_rx dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_rx_en(rx_en), .i_scl_pos_edge(pos),
    .i_scl_neg_edge(neg), .i_sda(sda), .o_word_valid(valid), .i_word_ready(rdy),
    .o_word_data(data), .o_word_kind(kind), .o_word_hit(hit), .o_word_err(err),
    .o_overflow(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic expect_e(input logic [15:0] d, input logic [1:0] k, input logic [1:0] h, input logic [2:0] e);
    q.push_back({d, k, h, e});
  endtask
  task automatic send_bit(input logic b);
    @(posedge clk); #2;
    sda = b;
    ph = (ph + 1) % 3;
    pos = ph != 1;
    neg = ph != 0;
    @(posedge clk); #2;
    pos = 0;
    neg = 0;
  endtask
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic send_word(input logic [1:0] pre, input logic [15:0] pl, input logic [1:0] par);
    send_bits(32'(pre), 2);
    send_bits(32'(pl), 16);
    send_bits(32'(par), 2);
  endtask
  task automatic send_crc(input logic [3:0] tok, input logic [4:0] crc);
    send_bits(32'h1, 2);
    send_bits(32'(tok), 4);
    send_bits(32'(crc), 5);
  endtask
  task automatic abort_rx();
    @(posedge clk); #2 rx_en = 0;
    repeat (2) @(posedge clk);
    #2 rx_en = 1;
    @(posedge clk); #2;
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check(name, 32'(q.size()), 0);
  endtask
  initial begin : monitor
    logic [22:0] e;
    forever begin
      @(negedge clk);
      if (valid && rdy) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got %h expected none", {data, kind, hit, err});
        end else begin
          e = q.pop_front();
          if ({data, kind, hit, err} !== e) begin
            n_err++;
            $display("FAIL word: got %h expected %h", {data, kind, hit, err}, e);
          end
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_outs", {data, kind, hit, err, ovf}, 0);
    @(posedge clk); #2 rst = 0; rx_en = 1;
    repeat (2) @(posedge clk);
    // 1: command to MY_ADDR, one-cycle push latency
    expect_e(16'h00CD, 2'b00, 2'b01, 3'b000);
    send_word(2'b01, 16'h00CD, 2'b10);
    check("t1_valid_before", 32'(valid), 0);
    @(posedge clk); #1;
    check("t1_valid_after", 32'(valid), 1);
    drain("t1_drain");
    abort_rx();
    expect_e(16'h00FC, 2'b00, 2'b10, 3'b000);
    send_word(2'b01, 16'h00FC, 2'b00);
    abort_rx();
    expect_e(16'h0012, 2'b00, 2'b00, 3'b000);
    send_word(2'b01, 16'h0012, 2'b00);
    drain("t1_bcast_drain");
    // 2: data parity good/bad, bad preamble
    expect_e(16'hA55A, 2'b01, 2'b00, 3'b000);
    send_word(2'b11, 16'hA55A, 2'b01);
    expect_e(16'hA55A, 2'b01, 2'b00, 3'b001);
    send_word(2'b11, 16'hA55A, 2'b10);
    expect_e(16'h0000, 2'b01, 2'b00, 3'b001);
    send_bits(32'h2, 2);
    drain("t2_drain");
    // 3: CRC word good, bad CRC, bad token (CRC5 of 16'h1234 from 5'h1F is 5'h10)
    abort_rx();
    expect_e(16'h00CD, 2'b00, 2'b01, 3'b000);
    send_word(2'b01, 16'h00CD, 2'b10);
    expect_e(16'h1234, 2'b01, 2'b00, 3'b000);
    send_word(2'b11, 16'h1234, 2'b00);
    expect_e(16'h0010, 2'b10, 2'b00, 3'b000);
    send_crc(4'b1100, 5'h10);
    expect_e(16'h00CD, 2'b00, 2'b01, 3'b000);
    send_word(2'b01, 16'h00CD, 2'b10);
    expect_e(16'h1234, 2'b01, 2'b00, 3'b000);
    send_word(2'b11, 16'h1234, 2'b00);
    expect_e(16'h0011, 2'b10, 2'b00, 3'b010);
    send_crc(4'b1100, 5'h11);
    expect_e(16'h00CD, 2'b00, 2'b01, 3'b000);
    send_word(2'b01, 16'h00CD, 2'b10);
    expect_e(16'h1234, 2'b01, 2'b00, 3'b000);
    send_word(2'b11, 16'h1234, 2'b00);
    expect_e(16'h0010, 2'b10, 2'b00, 3'b100);
    send_crc(4'b1110, 5'h10);
    drain("t3_drain");
    // 4: fill FIFO, push-with-pop while full, then overflow
    rdy = 0;
    expect_e(16'h0000, 2'b01, 2'b00, 3'b000);
    send_word(2'b11, 16'h0000, 2'b01);
    expect_e(16'h0001, 2'b01, 2'b00, 3'b000);
    send_word(2'b11, 16'h0001, 2'b00);
    expect_e(16'h0002, 2'b01, 2'b00, 3'b000);
    send_word(2'b11, 16'h0002, 2'b11);
    expect_e(16'h8000, 2'b01, 2'b00, 3'b000);
    send_word(2'b11, 16'h8000, 2'b11);
    @(posedge clk); #1;
    check("t4_full_ovf", 32'(ovf), 0);
    check("t4_head", 32'(data), 32'h0000);
    expect_e(16'hFFFF, 2'b01, 2'b00, 3'b000);
    send_word(2'b11, 16'hFFFF, 2'b01);
    rdy = 1;
    @(posedge clk); #2 rdy = 0;
    #1;
    check("t4_pushpop_ovf", 32'(ovf), 0);
    send_word(2'b11, 16'hA55A, 2'b01);
    @(posedge clk); #1;
    check("t4_ovf", 32'(ovf), 1);
    rdy = 1;
    drain("t4_drain");
    check("t4_ovf_sticky", 32'(ovf), 1);
    // 5: abort after 9 payload bits, then a command
    expect_e(16'h00CD, 2'b00, 2'b01, 3'b000);
    send_word(2'b01, 16'h00CD, 2'b10);
    drain("t5_cmd_drain");
    send_bits(32'h3, 2);
    send_bits(32'h17D, 9);
    @(posedge clk); #2 rx_en = 0;
    repeat (4) @(posedge clk);
    #1 check("t5_no_push", 32'(valid), 0);
    #1 rx_en = 1;
    @(posedge clk); #2;
    expect_e(16'h00CD, 2'b00, 2'b01, 3'b000);
    send_word(2'b01, 16'h00CD, 2'b10);
    drain("t5_drain");
    // 6: async reset mid-word with two queued entries
    rdy = 0;
    send_word(2'b11, 16'h0001, 2'b00);
    send_word(2'b11, 16'h0002, 2'b11);
    @(posedge clk); #1;
    check("t6_valid_pre", 32'(valid), 1);
    send_bits(32'h3, 2);
    send_bits(32'h15, 5);
    #1 rst = 1;
    #1;
    check("t6_valid_rst", 32'(valid), 0);
    check("t6_outs_rst", {data, kind, hit, err, ovf}, 0);
    @(posedge clk); #2 rst = 0;
    rdy = 1;
    repeat (2) @(posedge clk);
    expect_e(16'h00CD, 2'b00, 2'b01, 3'b000);
    send_word(2'b01, 16'h00CD, 2'b10);
    drain("t6_drain");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
